axi_ram_slave: RTL and testbench

Single-port AXI4-Lite RAM slave that sits directly downstream of the `picorv32_axi` memory interface in FPGA timing and bring-up builds. It terminates the core's `mem_axi_*` channels with word-addressed, byte-strobed storage and a programmable response latency. Reads and writes share one memory port and are served one transaction at a time, with writes taking priority.

---
 rtl/axi_ram_slave.sv | 185 ++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: single-port AXI4-Lite RAM slave for the picorv32_axi memory
// interface. One transaction in flight at a time, writes win over reads.
// Word-addressed byte-strobed storage with a programmable response latency.
module axi_ram_slave #(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 1
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        mem_axi_awvalid,
    output logic        mem_axi_awready,
    input  logic [31:0] mem_axi_awaddr,
    input  logic [2:0]  mem_axi_awprot,

    input  logic        mem_axi_wvalid,
    output logic        mem_axi_wready,
    input  logic [31:0] mem_axi_wdata,
    input  logic [3:0]  mem_axi_wstrb,

    output logic        mem_axi_bvalid,
    input  logic        mem_axi_bready,

    input  logic        mem_axi_arvalid,
    output logic        mem_axi_arready,
    input  logic [31:0] mem_axi_araddr,
    input  logic [2:0]  mem_axi_arprot,

    output logic        mem_axi_rvalid,
    input  logic        mem_axi_rready,
    output logic [31:0] mem_axi_rdata
);

    localparam int          AW       = $clog2(MEM_WORDS);
    localparam bit          ZERO_LAT = (LATENCY == 0);
    localparam logic [3:0]  LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [2:0] {
        RST,
        IDLE,
        WCOLLECT,
        WWAIT,
        WRESP,
        RWAIT,
        RRESP
    } state_t;

    state_t         state;
    logic           aw_got;
    logic           w_got;
    logic [AW-1:0]  idx_q;
    logic [31:0]    wdata_q;
    logic [3:0]     wstrb_q;
    logic [3:0]     cnt;
    logic [31:0]    rdata_q;

    logic [31:0]    mem [MEM_WORDS];

    // Output decode: everything comes from registered state, except arready,
    // which yields to a write presented in the same IDLE cycle.
    assign mem_axi_awready = (state == IDLE) || ((state == WCOLLECT) && !aw_got);
    assign mem_axi_wready  = (state == IDLE) || ((state == WCOLLECT) && !w_got);
    assign mem_axi_arready = (state == IDLE) && !mem_axi_awvalid && !mem_axi_wvalid;
    assign mem_axi_bvalid  = (state == WRESP);
    assign mem_axi_rvalid  = (state == RRESP);
    assign mem_axi_rdata   = rdata_q;

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    assign aw_hs = mem_axi_awvalid && mem_axi_awready;
    assign w_hs  = mem_axi_wvalid && mem_axi_wready;
    assign ar_hs = mem_axi_arvalid && mem_axi_arready;

    // Effective write operands: this cycle's handshake if any, else the latch.
    logic [AW-1:0] wr_idx;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    logic [AW-1:0] rd_idx;
    assign wr_idx  = aw_hs ? mem_axi_awaddr[AW+1:2] : idx_q;
    assign wr_data = w_hs  ? mem_axi_wdata : wdata_q;
    assign wr_strb = w_hs  ? mem_axi_wstrb : wstrb_q;
    assign rd_idx  = ar_hs ? mem_axi_araddr[AW+1:2] : idx_q;

    // Both halves of a write are present (aw_got/w_got are clear in IDLE).
    logic wr_done;
    logic wr_start;
    logic mem_we;
    logic rd_load;
    assign wr_done  = (aw_got || aw_hs) && (w_got || w_hs);
    assign wr_start = ((state == IDLE) || (state == WCOLLECT)) && wr_done;
    assign mem_we   = (wr_start && ZERO_LAT) || ((state == WWAIT) && (cnt == 4'd0));
    assign rd_load  = (ar_hs && ZERO_LAT) || ((state == RWAIT) && (cnt == 4'd0));

    // Protection bits and the address bits outside the word index are ignored.
    logic unused_bits;
    assign unused_bits = ^{mem_axi_awprot, mem_axi_arprot,
                           mem_axi_awaddr[31:AW+2], mem_axi_awaddr[1:0],
                           mem_axi_araddr[31:AW+2], mem_axi_araddr[1:0]};

    // Storage write port: only strobed bytes change, on entry to WRESP.
    // NOTE: the array has no reset; contents survive resetn so a core reboot
    // sees the same image, and a reset branch would prevent RAM inference.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    // Transaction FSM with request latches, latency counter and read register.
    // NOTE: state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= RST;
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            if (rd_load) begin
                rdata_q <= mem[rd_idx];
            end
            case (state)
                RST: state <= IDLE;
                IDLE, WCOLLECT: begin
                    if (aw_hs) begin
                        idx_q <= mem_axi_awaddr[AW+1:2];
                    end
                    if (w_hs) begin
                        wdata_q <= mem_axi_wdata;
                        wstrb_q <= mem_axi_wstrb;
                    end
                    if (wr_done) begin
                        aw_got <= 1'b0;
                        w_got  <= 1'b0;
                        cnt    <= LAT_M1;
                        state  <= ZERO_LAT ? WRESP : WWAIT;
                    end else if (aw_hs || w_hs) begin
                        aw_got <= aw_got || aw_hs;
                        w_got  <= w_got || w_hs;
                        state  <= WCOLLECT;
                    end else if (ar_hs) begin
                        idx_q <= mem_axi_araddr[AW+1:2];
                        cnt   <= LAT_M1;
                        state <= ZERO_LAT ? RRESP : RWAIT;
                    end
                end
                WWAIT: begin
                    if (cnt == 4'd0) begin
                        state <= WRESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RWAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RRESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WRESP: begin
                    if (mem_axi_bready) begin
                        state <= IDLE;
                    end
                end
                RRESP: begin
                    if (mem_axi_rready) begin
                        state <= IDLE;
                    end
                end
                default: state <= RST;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: two instances (LATENCY 1 and 4) driven by directed and
// randomized transactions; a reference word array predicts read data and the
// latency rules predict response timing.
module tb_axi_ram_slave;

    localparam int N     = 2;
    localparam int WORDS = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]        resetn;
    logic [N-1:0]        awvalid, wvalid, bready, arvalid, rready;
    logic [N-1:0][31:0]  awaddr, wdata, araddr;
    logic [N-1:0][3:0]   wstrb;
    logic [2:0]          prot = 3'b000;
    wire  [N-1:0]        awready, wready, bvalid, arready, rvalid;
    wire  [N-1:0][31:0]  rdata;

    // Reference model state.
    logic [31:0] ref_mem [N][WORDS];
    logic [N-1:0] pend_read  = '0;
    logic [N-1:0] pend_write = '0;
    logic [31:0]  exp_rd [N];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            axi_ram_slave #(
                .MEM_WORDS(WORDS),
                .LATENCY  ((g == 0) ? 1 : 4)
            ) u_dut (
                .clk            (clk),
                .resetn         (resetn[g]),
                .mem_axi_awvalid(awvalid[g]),
                .mem_axi_awready(awready[g]),
                .mem_axi_awaddr (awaddr[g]),
                .mem_axi_awprot (prot),
                .mem_axi_wvalid (wvalid[g]),
                .mem_axi_wready (wready[g]),
                .mem_axi_wdata  (wdata[g]),
                .mem_axi_wstrb  (wstrb[g]),
                .mem_axi_bvalid (bvalid[g]),
                .mem_axi_bready (bready[g]),
                .mem_axi_arvalid(arvalid[g]),
                .mem_axi_arready(arready[g]),
                .mem_axi_araddr (araddr[g]),
                .mem_axi_arprot (prot),
                .mem_axi_rvalid (rvalid[g]),
                .mem_axi_rready (rready[g]),
                .mem_axi_rdata  (rdata[g])
            );

            // Per-cycle compare against the model, away from the active edge.
            always @(negedge clk) begin
                if (!resetn[g]) begin
                    check("reset handshake outputs",
                          {27'd0, awready[g], wready[g], arready[g], bvalid[g], rvalid[g]}, 32'd0);
                    check("reset rdata", rdata[g], 32'd0);
                end else begin
                    if (rvalid[g]) begin
                        check1("rvalid only for pending read", pend_read[g], 1'b1);
                        check("rdata vs model", rdata[g], exp_rd[g]);
                    end
                    if (bvalid[g]) begin
                        check1("bvalid only for pending write", pend_write[g], 1'b1);
                    end
                    if (arready[g]) begin
                        check1("arready yields to write", awvalid[g] || wvalid[g], 1'b0);
                    end
                end
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One write; lead > 0 presents W that many cycles before AW, lead < 0 AW first.
    task automatic do_write(input int d, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] st, input int lead, input int bdelay,
                            input bit with_ar, input logic [31:0] ar_a);
        int aw_start, w_start, cyc, n, idx;
        bit aw_done, w_done, aw_fire, w_fire;
        aw_start = (lead > 0) ? lead : 0;
        w_start  = (lead < 0) ? -lead : 0;
        aw_done = 0; w_done = 0; aw_fire = 0; w_fire = 0; cyc = 0;
        forever begin
            tick();
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done  = 1;
            if ((aw_done && w_done) || cyc >= 100) break;
            awaddr[d]  = a;
            wdata[d]   = wd;
            wstrb[d]   = st;
            awvalid[d] = !aw_done && (cyc >= aw_start);
            wvalid[d]  = !w_done && (cyc >= w_start);
            if (with_ar && cyc == 0) begin
                arvalid[d] = 1'b1;
                araddr[d]  = ar_a;
            end
            #1;
            aw_fire = awvalid[d] && awready[d];
            w_fire  = wvalid[d] && wready[d];
            if (aw_done != w_done) begin
                check1("collect arready", arready[d], 1'b0);
                if (aw_done) check1("collect awready", awready[d], 1'b0);
                else         check1("collect wready", wready[d], 1'b0);
            end
            if (arvalid[d]) check1("ar blocked by write", arready[d], 1'b0);
            cyc++;
        end
        awvalid[d] = 1'b0;
        wvalid[d]  = 1'b0;
        check1("write handshake", aw_done && w_done, 1'b1);
        pend_write[d] = 1'b1;
        #1;
        n = 0;
        while (!bvalid[d] && n < 40) begin
            tick(); #1;
            if (arvalid[d]) check1("ar blocked during write wait", arready[d], 1'b0);
            n++;
        end
        check("write latency", n, lat_of(d));
        idx = int'(a[11:2]);
        for (int b = 0; b < 4; b++) begin
            if (st[b]) ref_mem[d][idx][8*b +: 8] = wd[8*b +: 8];
        end
        repeat (bdelay) begin
            tick(); #1;
            check1("bvalid stall", bvalid[d], 1'b1);
            if (arvalid[d]) check1("ar blocked during bvalid", arready[d], 1'b0);
        end
        tick();
        bready[d] = 1'b1;
        #1;
        if (arvalid[d]) check1("ar blocked at b handshake", arready[d], 1'b0);
        tick();
        bready[d] = 1'b0;
        pend_write[d] = 1'b0;
        #1;
        check1("bvalid drop", bvalid[d], 1'b0);
    endtask

    // One read; if arvalid is already held it continues that request.
    task automatic do_read(input int d, input logic [31:0] a, input int rdelay,
                           output logic [31:0] got, output int ar_wait);
        int n, idx;
        if (!arvalid[d]) begin
            tick();
            arvalid[d] = 1'b1;
            araddr[d]  = a;
        end
        #1;
        ar_wait = 0;
        while (!arready[d] && ar_wait < 100) begin
            tick(); #1;
            ar_wait++;
        end
        check1("ar accept", arready[d], 1'b1);
        idx = int'(a[11:2]);
        exp_rd[d]    = ref_mem[d][idx];
        pend_read[d] = 1'b1;
        tick();
        arvalid[d] = 1'b0;
        #1;
        n = 0;
        while (!rvalid[d] && n < 40) begin
            tick(); #1;
            n++;
        end
        check("read latency", n, lat_of(d));
        got = rdata[d];
        check("read data", rdata[d], exp_rd[d]);
        repeat (rdelay) begin
            tick(); #1;
            check1("rvalid stall", rvalid[d], 1'b1);
            check("rdata stall", rdata[d], exp_rd[d]);
        end
        tick();
        rready[d] = 1'b1;
        tick();
        rready[d] = 1'b0;
        pend_read[d] = 1'b0;
        #1;
        check1("rvalid drop", rvalid[d], 1'b0);
        check("rdata hold", rdata[d], exp_rd[d]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got, a;
        int w, idx;
        resetn  = '0;
        awvalid = '0; wvalid = '0; bready = '0; arvalid = '0; rready = '0;
        awaddr  = '0; wdata  = '0; wstrb  = '0; araddr  = '0;
        for (int d = 0; d < N; d++) exp_rd[d] = '0;

        // Reset: three cycles low, readies rise one cycle after release.
        repeat (3) @(posedge clk);
        #1;
        resetn = '1;
        #1;
        for (int d = 0; d < N; d++) begin
            check("readies right after release", {29'd0, awready[d], wready[d], arready[d]}, 32'd0);
        end
        tick();
        for (int d = 0; d < N; d++) begin
            check("readies one cycle after release", {29'd0, awready[d], wready[d], arready[d]}, 32'd7);
        end

        // Give words 0..15 known contents in both instances.
        for (int d = 0; d < N; d++) begin
            for (int i = 0; i < 16; i++) begin
                do_write(d, 32'(i * 4), $urandom, 4'hF, 0, 0, 1'b0, 32'd0);
            end
        end

        // Basic write then read.
        do_write(0, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0, 32'd0);
        do_read(0, 32'h10, 0, got, w);
        check("basic read literal", got, 32'hDEADBEEF);

        // Split write, W three cycles ahead of AW, partial strobe.
        do_write(0, 32'h10, 32'h11223344, 4'h5, 3, 0, 1'b0, 32'd0);
        do_read(0, 32'h10, 0, got, w);
        check("partial strobe literal", got, 32'hDE22BE44);

        // Priority: AW, W and AR in the same IDLE cycle.
        do_write(0, 32'h10, 32'hCAFEF00D, 4'hF, 0, 2, 1'b1, 32'h10);
        do_read(0, 32'h10, 0, got, w);
        check("ar accepted right after b", w, 0);
        check("priority read literal", got, 32'hCAFEF00D);

        // Wrap plus read backpressure.
        do_write(0, 32'h1000, 32'h5A5A5A5A, 4'hF, 0, 0, 1'b0, 32'd0);
        do_read(0, 32'h0, 5, got, w);
        check("wrap read literal", got, 32'h5A5A5A5A);

        // Zero strobe leaves memory alone; AW ahead of W.
        do_write(0, 32'h20, 32'h0BADC0DE, 4'h0, 0, 1, 1'b0, 32'd0);
        do_read(0, 32'h20, 0, got, w);
        do_write(0, 32'h24, 32'h87654321, 4'hA, -2, 1, 1'b0, 32'd0);
        do_read(0, 32'h24, 1, got, w);

        // Abort a read in RWAIT on the LATENCY=4 instance.
        tick();
        arvalid[1] = 1'b1;
        araddr[1]  = 32'h1C;
        #1;
        check1("abort ar accept", arready[1], 1'b1);
        tick();
        arvalid[1] = 1'b0;
        repeat (2) begin
            tick(); #1;
            check1("abort rvalid in wait", rvalid[1], 1'b0);
        end
        resetn[1] = 1'b0;
        #1;
        check1("abort rvalid in reset", rvalid[1], 1'b0);
        repeat (3) tick();
        resetn[1] = 1'b1;
        repeat (8) begin
            tick(); #1;
            check1("no rvalid after abort", rvalid[1], 1'b0);
        end
        do_read(1, 32'h1C, 1, got, w);

        // Randomized traffic on both instances.
        for (int d = 0; d < N; d++) begin
            repeat (60) begin
                idx = int'($urandom_range(0, 15));
                a = $urandom;
                a[11:2] = 10'(idx);
                if ($urandom_range(0, 1) == 1) begin
                    do_write(d, a, $urandom, 4'($urandom_range(0, 15)),
                             int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 3)),
                             1'b0, 32'd0);
                end else begin
                    do_read(d, a, int'($urandom_range(0, 3)), got, w);
                end
            end
        end

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
